// File: rtl/kbd_arrow_decoder.sv
// PS/2 set-2 scan byte decoder: held arrow-key levels plus a one-cycle key event per completed code.
// Optional WASD_ALIAS_EN: non-extended W/S/A/D drive the same levels, OR'd with the arrow keys.
module kbd_arrow_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 1_600_000,
  parameter int unsigned PAUSE_SKIP     = 7
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_err,
  output logic       leftPressed,
  output logic       rightPressed,
  output logic       upPressed,
  output logic       downPressed,
  output logic       keyEvent,
  output logic [8:0] keyCode,
  output logic       keyMake
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned SW = $clog2(PAUSE_SKIP + 1);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] skip_q, skip_d;
  logic [3:0]    arrow_q, arrow_d;  // {down, up, right, left}
  logic          ev_q, ev_d;
  logic [8:0]    code_q, code_d;
  logic          make_q, make_d;
  logic          done, done_ext, done_make;
  logic [3:0]    lvl;

  function automatic logic [3:0] arrow_mask(input logic [7:0] b);
    case (b)
      8'h6B:   arrow_mask = 4'b0001;
      8'h74:   arrow_mask = 4'b0010;
      8'h75:   arrow_mask = 4'b0100;
      8'h72:   arrow_mask = 4'b1000;
      default: arrow_mask = 4'b0000;
    endcase
  endfunction

`ifdef WASD_ALIAS_EN
  logic [3:0] alias_q, alias_d;

  function automatic logic [3:0] alias_mask(input logic [7:0] b);
    case (b)
      8'h1C:   alias_mask = 4'b0001;
      8'h23:   alias_mask = 4'b0010;
      8'h1D:   alias_mask = 4'b0100;
      8'h1B:   alias_mask = 4'b1000;
      default: alias_mask = 4'b0000;
    endcase
  endfunction

  assign lvl = arrow_q | alias_q;
`else
  assign lvl = arrow_q;
`endif

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    skip_d    = skip_q;
    arrow_d   = arrow_q;
`ifdef WASD_ALIAS_EN
    alias_d   = alias_q;
`endif
    ev_d      = 1'b0;
    code_d    = code_q;
    make_d    = make_q;
    done      = 1'b0;
    done_ext  = 1'b0;
    done_make = 1'b0;

    if (rx_err) begin
      // receiver error aborts any partial code, even with a coincident strobe
      state_d = IDLE;
      tmo_d   = '0;
    end else if (rx_valid) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          case (rx_data)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = SKIP;
              skip_d  = SW'(PAUSE_SKIP);
            end
            8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: ;
            default: begin
              done      = 1'b1;
              done_make = 1'b1;
            end
          endcase
        end
        EXT: begin
          if (rx_data == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (rx_data != 8'hE0) begin
            done      = 1'b1;
            done_ext  = 1'b1;
            done_make = 1'b1;
          end
        end
        BRK: done = 1'b1;
        EXT_BRK: begin
          done     = 1'b1;
          done_ext = 1'b1;
        end
        SKIP: begin
          skip_d = skip_q - SW'(1);
          if (skip_q <= SW'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (done) begin
        state_d = IDLE;
        ev_d    = 1'b1;
        code_d  = {done_ext, rx_data};
        make_d  = done_make;
        if (done_ext) begin
          arrow_d = done_make ? (arrow_q | arrow_mask(rx_data))
                              : (arrow_q & ~arrow_mask(rx_data));
        end
`ifdef WASD_ALIAS_EN
        else begin
          alias_d = done_make ? (alias_q | alias_mask(rx_data))
                              : (alias_q & ~alias_mask(rx_data));
        end
`endif
      end
    end else if (state_q != IDLE) begin
      // inter-byte watchdog: a stalled prefix is dropped silently
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      skip_q  <= '0;
      arrow_q <= '0;
`ifdef WASD_ALIAS_EN
      alias_q <= '0;
`endif
      ev_q    <= 1'b0;
      code_q  <= '0;
      make_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      skip_q  <= skip_d;
      arrow_q <= arrow_d;
`ifdef WASD_ALIAS_EN
      alias_q <= alias_d;
`endif
      ev_q    <= ev_d;
      code_q  <= code_d;
      make_q  <= make_d;
    end
  end

  assign leftPressed  = lvl[0];
  assign rightPressed = lvl[1];
  assign upPressed    = lvl[2];
  assign downPressed  = lvl[3];
  assign keyEvent     = ev_q;
  assign keyCode      = code_q;
  assign keyMake      = make_q;

endmodule
